// File: rtl/pattern_loader.sv
`default_nettype none
// ============================================================================
// pattern_loader : byte-stream to MSB-first serial loader for the pattern
//                  buffer; optional sout readback under PATLOAD_READBACK_EN.
// Revision       : 1.0
// ============================================================================
module pattern_loader #(
   parameter int NBYTES = 27
) (
   input  logic       sclk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       busy,
   output logic       done,
   output logic       ssel,
   output logic       sin,
   input  logic       sout,
   output logic       rd_valid,
   output logic [7:0] rd_data
);

   localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [7:0]     shreg;
   logic [2:0]     bitcnt;
   logic [BCW-1:0] bytecnt;
   logic           last_bit;
   logic           last_byte;
   logic           accept;

   // in_ready reaches back into SHIFT so consecutive bytes stream with no gap
   always_comb begin
      last_bit   = (state == SHIFT) && (bitcnt == 3'd0);
      last_byte  = (bytecnt == LAST_BYTE);
      in_ready   = (state == LOAD) || (last_bit && !last_byte);
      accept     = in_valid && in_ready;
      busy       = (state != IDLE);
      done       = (state == DONE);
      ssel       = (state == SHIFT);
      sin        = (state == SHIFT) && shreg[7];
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (accept) state_next = SHIFT;
         SHIFT: begin
            if (last_bit) begin
               if (last_byte)    state_next = DONE;
               else if (!accept) state_next = LOAD;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         shreg   <= 8'd0;
         bitcnt  <= 3'd0;
         bytecnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) bytecnt <= '0;
            end
            LOAD: begin
               if (accept) begin
                  shreg  <= in_data;
                  bitcnt <= 3'd7;
               end
            end
            SHIFT: begin
               if (last_bit && accept) begin
                  shreg  <= in_data;
                  bitcnt <= 3'd7;
               end else begin
                  shreg  <= {shreg[6:0], 1'b0};
                  bitcnt <= bitcnt - 3'd1;
               end
               if (last_bit && !last_byte) bytecnt <= bytecnt + BCW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef PATLOAD_READBACK_EN
   logic [7:0] rb_sreg;
   logic [2:0] rb_cnt;
   logic       rb_valid;

   // sout advances in lockstep with sin, so capture on the same ssel edges
   always_ff @(posedge sclk) begin
      if (reset) begin
         rb_sreg  <= 8'd0;
         rb_cnt   <= 3'd0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= ssel && (rb_cnt == 3'd7);
         if (ssel) begin
            rb_sreg <= {rb_sreg[6:0], sout};
            rb_cnt  <= rb_cnt + 3'd1;
         end
      end
   end

   assign rd_valid = rb_valid;
   assign rd_data  = rb_valid ? rb_sreg : 8'd0;
`else
   logic unused_sout;

   assign rd_valid    = 1'b0;
   assign rd_data     = 8'd0;
   assign unused_sout = sout;
`endif

endmodule
`default_nettype wire
